branch_resolve_ctrl: RTL

- Sequences the hybrid branch predictor.
- Holds in-flight predictions in order, checks each one against the MEM-stage resolution, and raises a single-cycle flush with a redirect PC on a misprediction.
- Queues training updates (BTB, global, local and meta tables) and hands them to the predictor through a valid/ready port.
- Sits between fetch (prediction producer), MEM (resolver) and the predictor tables.

---
 rtl/bp_ctrl_pkg.sv | 13 +
 rtl/bp_sync_fifo.sv | 46 ++++
 rtl/branch_resolve_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/bp_ctrl_pkg.sv
// bp_ctrl_pkg: shared FSM encoding, instruction size and queue entry widths for the branch resolve controller.
package bp_ctrl_pkg;
  typedef enum logic {NORMAL, RECOVER} state_t;
  localparam int INSTR_BYTES = 4;
  // Prediction entry layout {addr, taken, target, comps}.
  function automatic int pred_w(input int aw);
    return aw * 2 + 3;
  endfunction
  // Update entry layout {addr, actual taken, actual target, comps}.
  function automatic int upd_w(input int aw);
    return aw * 2 + 3;
  endfunction
endpackage

// File: rtl/bp_sync_fifo.sv
// bp_sync_fifo: synchronous FIFO with synchronous clear; full/empty come from the occupancy counter.
module bp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: tracks in-flight predictions, checks them against MEM resolution,
// flushes/redirects on mispredict and queues training updates for the predictor tables.
module branch_resolve_ctrl
  import bp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int UPD_DEPTH = 2,
  parameter int AW = 32
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Pred_valid,
  input  logic [AW-1:0]                Pred_addr,
  input  logic                         Pred_taken,
  input  logic [AW-1:0]                Pred_target,
  input  logic [1:0]                   Pred_comps,
  input  logic                         Res_valid,
  input  logic                         Res_taken,
  input  logic [AW-1:0]                Res_target,
  output logic                         Res_ready,
  output logic                         Upd_valid,
  input  logic                         Upd_ready,
  output logic [AW-1:0]                Upd_addr,
  output logic                         Upd_taken,
  output logic [AW-1:0]                Upd_target,
  output logic [1:0]                   Upd_comps,
  output logic                         Flush,
  output logic [AW-1:0]                Redirect_addr,
  output logic                         Stall,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);
  localparam int PW_E = pred_w(AW);
  localparam int UW_E = upd_w(AW);
  state_t state;
  logic [PW_E-1:0] pq_dout;
  logic [AW-1:0] h_addr, h_target;
  logic h_taken;
  logic [1:0] h_comps;
  logic pq_empty, uq_full, uq_empty, resolve, mispredict;
  logic [$clog2(UPD_DEPTH+1)-1:0] uq_count;
  logic unused_uq;
  assign {h_addr, h_taken, h_target, h_comps} = pq_dout;
  assign Res_ready = RESET && state == NORMAL && !uq_full;
  assign resolve = Res_valid && Res_ready && !pq_empty;
  assign mispredict = resolve && ((Res_taken != h_taken) || (Res_taken && Res_target != h_target));
  assign Upd_valid = !uq_empty;
  assign unused_uq = ^uq_count;
  bp_sync_fifo #(.WIDTH(PW_E), .DEPTH(DEPTH)) u_pred_q (
    .CLK(CLK), .RESET(RESET),
    .push(Pred_valid && state == NORMAL), .pop(resolve), .clear(mispredict),
    .din({Pred_addr, Pred_taken, Pred_target, Pred_comps}), .dout(pq_dout),
    .full(Stall), .empty(pq_empty), .count(Count)
  );
  bp_sync_fifo #(.WIDTH(UW_E), .DEPTH(UPD_DEPTH)) u_upd_q (
    .CLK(CLK), .RESET(RESET),
    .push(resolve), .pop(Upd_ready), .clear(1'b0),
    .din({h_addr, Res_taken, Res_target, h_comps}),
    .dout({Upd_addr, Upd_taken, Upd_target, Upd_comps}),
    .full(uq_full), .empty(uq_empty), .count(uq_count)
  );
  // RECOVER lasts one cycle; no resolve can occur there since Res_ready is low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= NORMAL;
      Flush <= 1'b0;
      Redirect_addr <= '0;
    end else begin
      state <= mispredict ? RECOVER : NORMAL;
      Flush <= mispredict;
      Redirect_addr <= !mispredict ? '0 : Res_taken ? Res_target : h_addr + AW'(INSTR_BYTES);
    end
  end
endmodule
